// File: rtl/vga_mode_ctrl.sv
// Mode controller for the VGA timing counter: frame-aligned mode switches, halt/load/settle blanking.
// Define VGA_CUSTOM_MODE_EN to add a programmable mode 3 written through the cfg_* port.
module vga_mode_ctrl #(
  parameter int unsigned W             = 12,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned TIMEOUT_CYC   = 1000000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mode_req_i,
  input  logic [1:0]   mode_sel_i,
  input  logic         frame_end_i,
`ifdef VGA_CUSTOM_MODE_EN
  input  logic         cfg_we_i,
  input  logic [3:0]   cfg_addr_i,
  input  logic [W-1:0] cfg_data_i,
`endif
  output logic         mode_ack_o,
  output logic         mode_err_o,
  output logic         busy_o,
  output logic [1:0]   cur_mode_o,
  output logic         cnt_en_o,
  output logic         blank_o,
  output logic [W-1:0] h_visible_o,
  output logic [W-1:0] h_front_o,
  output logic [W-1:0] h_sync_o,
  output logic [W-1:0] h_back_o,
  output logic [W-1:0] h_whole_o,
  output logic [W-1:0] v_visible_o,
  output logic [W-1:0] v_front_o,
  output logic [W-1:0] v_sync_o,
  output logic [W-1:0] v_back_o,
  output logic [W-1:0] v_whole_o
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned SW = 4;

  // Entries 0..4: H vis,fp,sync,bp,whole; 5..9: V vis,fp,sync,bp,whole.
  typedef logic [9:0][W-1:0] tset_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_HALT, ST_LOAD, ST_SETTLE, ST_DONE, ST_REJECT
  } state_t;

  function automatic tset_t tbl(input logic [1:0] m);
    tset_t t;
    case (m)
      2'd1: begin
        t[0] = W'(800);  t[1] = W'(40); t[2] = W'(128); t[3] = W'(88);  t[4] = W'(1056);
        t[5] = W'(600);  t[6] = W'(1);  t[7] = W'(4);   t[8] = W'(23);  t[9] = W'(628);
      end
      2'd2: begin
        t[0] = W'(1024); t[1] = W'(24); t[2] = W'(136); t[3] = W'(160); t[4] = W'(1344);
        t[5] = W'(768);  t[6] = W'(3);  t[7] = W'(6);   t[8] = W'(29);  t[9] = W'(806);
      end
      default: begin
        t[0] = W'(640);  t[1] = W'(16); t[2] = W'(96);  t[3] = W'(48);  t[4] = W'(800);
        t[5] = W'(480);  t[6] = W'(10); t[7] = W'(2);   t[8] = W'(33);  t[9] = W'(525);
      end
    endcase
    return t;
  endfunction

  state_t        state_q;
  tset_t         tim_q;
  logic [1:0]    sel_q;
  logic [1:0]    cur_mode_q;
  logic [TW-1:0] to_cnt_q;
  logic [SW-1:0] set_cnt_q;
  logic          busy_q, ack_q, err_q, cnt_en_q, blank_q;
  logic          sel_valid_c;
  tset_t         load_val_c;

`ifdef VGA_CUSTOM_MODE_EN
  tset_t shadow_q;

  // Shadow registers only reach the live timing through a mode-3 load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= tbl(2'd0);
    end else if (cfg_we_i && (cfg_addr_i < 4'd10)) begin
      shadow_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  assign sel_valid_c = 1'b1;
  assign load_val_c  = (sel_q == 2'd3) ? shadow_q : tbl(sel_q);
`else
  assign sel_valid_c = (mode_sel_i != 2'd3);
  assign load_val_c  = tbl(sel_q);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tim_q      <= tbl(2'd0);
      sel_q      <= 2'd0;
      cur_mode_q <= 2'd0;
      to_cnt_q   <= '0;
      set_cnt_q  <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt_en_q   <= 1'b1;
      blank_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (mode_req_i) begin
            busy_q <= 1'b1;
            sel_q  <= mode_sel_i;
            if (!sel_valid_c) begin
              state_q <= ST_REJECT;
              err_q   <= 1'b1;
            end else if (mode_sel_i == cur_mode_q) begin
              state_q <= ST_DONE;
            end else begin
              state_q  <= ST_WAIT;
              to_cnt_q <= '0;
            end
          end
        end
        ST_REJECT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        // A stalled counter never sends frame_end, so the timeout forces the switch.
        ST_WAIT: begin
          if (frame_end_i || (to_cnt_q == TW'(TIMEOUT_CYC - 1))) begin
            state_q  <= ST_HALT;
            cnt_en_q <= 1'b0;
            blank_q  <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        ST_HALT: begin
          state_q    <= ST_LOAD;
          tim_q      <= load_val_c;
          cur_mode_q <= sel_q;
        end
        ST_LOAD: begin
          state_q   <= ST_SETTLE;
          cnt_en_q  <= 1'b1;
          set_cnt_q <= '0;
        end
        ST_SETTLE: begin
          if (frame_end_i) begin
            if (set_cnt_q == SW'(SETTLE_FRAMES - 1)) begin
              state_q <= ST_DONE;
              blank_q <= 1'b0;
            end else begin
              set_cnt_q <= set_cnt_q + SW'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mode_ack_o  = ack_q;
  assign mode_err_o  = err_q;
  assign busy_o      = busy_q;
  assign cur_mode_o  = cur_mode_q;
  assign cnt_en_o    = cnt_en_q;
  assign blank_o     = blank_q;
  assign h_visible_o = tim_q[0];
  assign h_front_o   = tim_q[1];
  assign h_sync_o    = tim_q[2];
  assign h_back_o    = tim_q[3];
  assign h_whole_o   = tim_q[4];
  assign v_visible_o = tim_q[5];
  assign v_front_o   = tim_q[6];
  assign v_sync_o    = tim_q[7];
  assign v_back_o    = tim_q[8];
  assign v_whole_o   = tim_q[9];

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: per-cycle vector table plus a hand-written timeout sequence.
module tb_vga_mode_ctrl;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst, mode_req, frame_end;
  logic [1:0]   mode_sel;
  logic         mode_ack, mode_err, busy, cnt_en, blank;
  logic [1:0]   cur_mode;
  logic [W-1:0] h_visible, h_front, h_sync, h_back, h_whole;
  logic [W-1:0] v_visible, v_front, v_sync, v_back, v_whole;

  int checks = 0;
  int errors = 0;

  vga_mode_ctrl #(.W(W), .SETTLE_FRAMES(2), .TIMEOUT_CYC(100)) dut (
    .clk_i(clk), .rst_i(rst), .mode_req_i(mode_req), .mode_sel_i(mode_sel),
    .frame_end_i(frame_end), .mode_ack_o(mode_ack), .mode_err_o(mode_err),
    .busy_o(busy), .cur_mode_o(cur_mode), .cnt_en_o(cnt_en), .blank_o(blank),
    .h_visible_o(h_visible), .h_front_o(h_front), .h_sync_o(h_sync), .h_back_o(h_back),
    .h_whole_o(h_whole), .v_visible_o(v_visible), .v_front_o(v_front), .v_sync_o(v_sync),
    .v_back_o(v_back), .v_whole_o(v_whole)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, req, fe;
    logic [1:0]  sel;
    logic        busy, ack, err, en, blank;
    logic [1:0]  mode;
    logic [11:0] hw, vw;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int r, input int q, input int s, input int f,
                     input int b, input int a, input int e, input int en,
                     input int bl, input int m, input int hw, input int vw);
    vec_t v;
    v.rst = 1'(r); v.req = 1'(q); v.sel = 2'(s); v.fe = 1'(f);
    v.busy = 1'(b); v.ack = 1'(a); v.err = 1'(e); v.en = 1'(en); v.blank = 1'(bl);
    v.mode = 2'(m); v.hw = 12'(hw); v.vw = 12'(vw);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode_req = 1'b0; mode_sel = 2'd0; frame_end = 1'b0;

    // Columns: rst req sel fe | busy ack err cnt_en blank cur_mode h_whole v_whole (after the edge)
    add(1,0,0,0, 0,0,0,1,0, 0, 800, 525);   // reset
    add(0,0,0,0, 0,0,0,1,0, 0, 800, 525);   // idle
    add(0,1,1,0, 1,0,0,1,0, 0, 800, 525);   // accept sel=1 -> wait frame
    add(0,0,1,0, 1,0,0,1,0, 0, 800, 525);
    add(0,0,1,1, 1,0,0,0,1, 0, 800, 525);   // frame_end -> halt
    add(0,0,1,1, 1,0,0,0,1, 1, 1056, 628);  // load; frame_end during halt ignored
    add(0,0,1,1, 1,0,0,1,1, 1, 1056, 628);  // settle; frame_end during load ignored
    add(0,0,1,0, 1,0,0,1,1, 1, 1056, 628);
    add(0,0,1,1, 1,0,0,1,1, 1, 1056, 628);  // first counted frame
    add(0,0,1,0, 1,0,0,1,1, 1, 1056, 628);
    add(0,0,1,1, 1,0,0,1,0, 1, 1056, 628);  // second frame -> done, unblank
    add(0,0,1,0, 1,1,0,1,0, 1, 1056, 628);  // ack
    add(0,0,1,0, 0,0,0,1,0, 1, 1056, 628);  // busy drops
    add(0,1,1,0, 1,0,0,1,0, 1, 1056, 628);  // same mode -> done directly
    add(0,0,1,0, 1,1,0,1,0, 1, 1056, 628);  // ack two edges after request
    add(0,0,1,0, 0,0,0,1,0, 1, 1056, 628);
    add(0,1,3,0, 1,0,1,1,0, 1, 1056, 628);  // mode 3 rejected
    add(0,0,3,0, 0,0,0,1,0, 1, 1056, 628);
    add(0,1,2,0, 1,0,0,1,0, 1, 1056, 628);  // accept sel=2
    add(0,0,2,1, 1,0,0,0,1, 1, 1056, 628);  // halt
    add(0,0,2,0, 1,0,0,0,1, 2, 1344, 806);  // load
    add(0,0,2,0, 1,0,0,1,1, 2, 1344, 806);  // settle
    add(0,0,2,1, 1,0,0,1,1, 2, 1344, 806);
    add(0,0,2,0, 0,0,0,1,0, 0, 800, 525);   // reset row, rst set on the next line
    vq[vq.size()-1].rst = 1'b1;              // reset mid-settle
    add(0,0,0,0, 0,0,0,1,0, 0, 800, 525);

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; mode_req = vq[i].req; mode_sel = vq[i].sel; frame_end = vq[i].fe;
      step();
      chk($sformatf("v%0d.busy", i), int'(busy), int'(vq[i].busy));
      chk($sformatf("v%0d.ack", i), int'(mode_ack), int'(vq[i].ack));
      chk($sformatf("v%0d.err", i), int'(mode_err), int'(vq[i].err));
      chk($sformatf("v%0d.cnt_en", i), int'(cnt_en), int'(vq[i].en));
      chk($sformatf("v%0d.blank", i), int'(blank), int'(vq[i].blank));
      chk($sformatf("v%0d.cur_mode", i), int'(cur_mode), int'(vq[i].mode));
      chk($sformatf("v%0d.h_whole", i), int'(h_whole), int'(vq[i].hw));
      chk($sformatf("v%0d.v_whole", i), int'(v_whole), int'(vq[i].vw));
    end
    rst = 1'b0; mode_req = 1'b0; frame_end = 1'b0;

    // Timeout: no frame_end, forced halt on the 100th edge after acceptance.
    mode_req = 1'b1; mode_sel = 2'd2;
    step();
    chk("to.accept_busy", int'(busy), 1);
    mode_req = 1'b0; mode_sel = 2'd1;       // ignored while busy
    for (int i = 1; i < 100; i++) step();
    chk("to.edge99_cnt_en", int'(cnt_en), 1);
    chk("to.edge99_blank", int'(blank), 0);
    step();
    chk("to.halt_cnt_en", int'(cnt_en), 0);
    chk("to.halt_blank", int'(blank), 1);
    chk("to.halt_h_whole", int'(h_whole), 800);
    step();
    chk("to.load_cnt_en", int'(cnt_en), 0);
    chk("to.load_mode", int'(cur_mode), 2);
    chk("to.h_visible", int'(h_visible), 1024);
    chk("to.h_front", int'(h_front), 24);
    chk("to.h_sync", int'(h_sync), 136);
    chk("to.h_back", int'(h_back), 160);
    chk("to.h_whole", int'(h_whole), 1344);
    chk("to.v_visible", int'(v_visible), 768);
    chk("to.v_front", int'(v_front), 3);
    chk("to.v_sync", int'(v_sync), 6);
    chk("to.v_back", int'(v_back), 29);
    chk("to.v_whole", int'(v_whole), 806);
    step();
    chk("to.settle_cnt_en", int'(cnt_en), 1);
    chk("to.settle_blank", int'(blank), 1);
    frame_end = 1'b1; step(); frame_end = 1'b0; step();
    chk("to.after_fe1_blank", int'(blank), 1);
    frame_end = 1'b1; step(); frame_end = 1'b0;
    chk("to.after_fe2_blank", int'(blank), 0);
    chk("to.after_fe2_ack", int'(mode_ack), 0);
    begin
      int n = 0;
      while (!mode_ack && n < 8) begin step(); n++; end
      chk("to.ack_seen", int'(mode_ack), 1);
      chk("to.ack_latency", n, 1);
    end
    step();
    chk("to.ack_pulse", int'(mode_ack), 0);
    chk("to.busy_drop", int'(busy), 0);
    chk("to.final_mode", int'(cur_mode), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
